// File: rtl/fpu_add_pkg.sv
// Shared definitions for the FP adder sequencing controller.
//   state_e           : controller FSM states
//   EXP_MAX           : biased exponent value that means overflow
//   FP_EXP_ONES/...   : IEEE-754 single field constants for NaN/Inf detection
//   *_DEFAULT         : default parameter values for fp_add_ctrl
package fpu_add_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StAdd,
    StNorm,
    StPack,
    StDone
  } state_e;

  localparam int EXP_MAX = 255;

  localparam logic [7:0]  FP_EXP_ONES = 8'hFF;
  localparam logic [22:0] FP_MAN_ZERO = 23'h0;

  localparam int unsigned SHIFT_SAT_DEFAULT = 56;
  localparam int unsigned NORM_MAX_DEFAULT  = 56;

endpackage

// File: rtl/fp_class.sv
// Combinational IEEE-754 single-precision classifier.
//   value  : 32-bit operand
//   is_nan : exponent all ones, mantissa non-zero
//   is_inf : exponent all ones, mantissa zero
//   sign   : sign bit
module fp_class
  import fpu_add_pkg::*;
(
  input  logic [31:0] value,
  output logic        is_nan,
  output logic        is_inf,
  output logic        sign
);

  logic [7:0]  exp_field;
  logic [22:0] man_field;

  always_comb begin
    exp_field = value[30:23];
    man_field = value[22:0];
    sign      = value[31];
    is_nan    = (exp_field == FP_EXP_ONES) && (man_field != FP_MAN_ZERO);
    is_inf    = (exp_field == FP_EXP_ONES) && (man_field == FP_MAN_ZERO);
  end

endmodule

// File: rtl/fp_add_ctrl.sv
// Sequencing controller for the multi-cycle FP adder datapath.
//   clk, rst                : clock, synchronous active-high reset
//   in_valid/in_ready       : operand handshake; in_a/in_b/in_sub classified on accept
//   dp_load                 : operands latched by datapath (accept cycle)
//   dp_align_en/add/norm/out: Moore stage enables for ALIGN/ADD/NORM/PACK
//   dp_sum_zero, norm_done  : datapath status, sampled in ADD / NORM
//   exp_result              : signed exponent after normalisation
//   *_flag, excessive_shift_left : registered on PACK entry, held through DONE
//   out_valid/out_ready     : result handshake
module fp_add_ctrl
  import fpu_add_pkg::*;
#(
  parameter int unsigned NORM_MAX  = NORM_MAX_DEFAULT,
  parameter int unsigned SHIFT_SAT = SHIFT_SAT_DEFAULT,
  parameter int unsigned EXP_W     = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_a,
  input  logic [31:0]             in_b,
  input  logic                    in_sub,
  output logic                    dp_load,
  output logic                    dp_align_en,
  output logic                    dp_add_en,
  output logic                    dp_norm_en,
  output logic                    dp_out_en,
  input  logic                    dp_sum_zero,
  input  logic                    norm_done,
  input  logic signed [EXP_W-1:0] exp_result,
  output logic                    overflow_flag,
  output logic                    underflow_flag,
  output logic                    invalid_flag,
  output logic [9:0]              excessive_shift_left,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned CntW = (NORM_MAX > 1) ? $clog2(NORM_MAX) : 1;

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;
  logic [9:0] shift_q, shift_d;

  logic nan_a, inf_a, sign_a, nan_b, inf_b, sign_b;
  logic invalid, inf_any, accept;
  int   exp_int, shift_raw;
  logic [9:0] shift_sat;

  fp_class u_class_a (.value(in_a), .is_nan(nan_a), .is_inf(inf_a), .sign(sign_a));
  fp_class u_class_b (.value(in_b), .is_nan(nan_b), .is_inf(inf_b), .sign(sign_b));

  always_comb begin
    // Inf - Inf (effective subtraction of equal infinities) has no defined result.
    invalid = nan_a | nan_b | (inf_a & inf_b & (sign_a ^ sign_b ^ in_sub));
    inf_any = (inf_a | inf_b) & ~invalid;
    accept  = in_valid & in_ready;

    exp_int   = int'(exp_result);
    shift_raw = 1 - exp_int;
    shift_sat = (shift_raw > int'(SHIFT_SAT)) ? 10'(SHIFT_SAT) : 10'(shift_raw);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Counter and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inv_q   <= 1'b0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inv_q   <= inv_d;
      shift_q <= shift_d;
    end
  end

  // Next state, counter and flags
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    inv_d   = inv_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (invalid) begin
            state_d = StPack;
            inv_d   = 1'b1;
          end else if (inf_any) begin
            state_d = StPack;
            ovf_d   = 1'b1;
          end else begin
            state_d = StAlign;
          end
        end
      end
      StAlign: state_d = StAdd;
      StAdd: begin
        if (dp_sum_zero) begin
          state_d = StPack;
          unf_d   = 1'b1;
          shift_d = '0;
        end else begin
          state_d = StNorm;
          cnt_d   = '0;
        end
      end
      StNorm: begin
        if (norm_done) begin
          state_d = StPack;
          if (exp_int >= EXP_MAX) begin
            ovf_d = 1'b1;
          end else if (exp_int <= 0) begin
            unf_d   = 1'b1;
            shift_d = shift_sat;
          end
        end else if (cnt_q == CntW'(NORM_MAX - 1)) begin
          // Normalisation never found a leading one: force a zero result.
          state_d = StPack;
          unf_d   = 1'b1;
          shift_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPack: state_d = StDone;
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          inv_d   = 1'b0;
          shift_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; gated by rst so an aborted operation never signals completion.
  always_comb begin
    in_ready             = ~rst & (state_q == StIdle);
    dp_load              = in_valid & in_ready;
    dp_align_en          = ~rst & (state_q == StAlign);
    dp_add_en            = ~rst & (state_q == StAdd);
    dp_norm_en           = ~rst & (state_q == StNorm);
    dp_out_en            = ~rst & (state_q == StPack);
    out_valid            = ~rst & (state_q == StDone);
    overflow_flag        = ovf_q;
    underflow_flag       = unf_q;
    invalid_flag         = inv_q;
    excessive_shift_left = shift_q;
  end

endmodule

// File: tb/tb_fp_add_ctrl.sv
module tb_fp_add_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic        dp_load, dp_align_en, dp_add_en, dp_norm_en, dp_out_en;
  logic        dp_sum_zero = 1'b0;
  logic        norm_done = 1'b0;
  logic [9:0]  exp_result = '0;
  logic        overflow_flag, underflow_flag, invalid_flag;
  logic [9:0]  excessive_shift_left;
  logic        out_valid;
  logic        out_ready = 1'b0;

  fp_add_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .dp_load(dp_load), .dp_align_en(dp_align_en), .dp_add_en(dp_add_en),
    .dp_norm_en(dp_norm_en), .dp_out_en(dp_out_en),
    .dp_sum_zero(dp_sum_zero), .norm_done(norm_done), .exp_result(exp_result),
    .overflow_flag(overflow_flag), .underflow_flag(underflow_flag),
    .invalid_flag(invalid_flag), .excessive_shift_left(excessive_shift_left),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       ovf;
    logic       unf;
    logic       inv;
    logic [9:0] shift;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   acc_cyc = 0;
  int   first_cyc = 0;
  logic prev_ov = 1'b0;
  int   op_wait = 0;
  int   norm_seen = 0;
  int   ready_delay = 0;
  int   stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Datapath and consumer models, updated just after each edge.
  always @(posedge clk) begin
    #1;
    if (dp_add_en) norm_seen = 0;
    if (dp_norm_en) begin
      norm_done = (norm_seen >= op_wait);
      norm_seen++;
    end else begin
      norm_done = 1'b0;
    end
    if (out_valid) begin
      out_ready = (stall_cnt >= ready_delay);
      stall_cnt++;
    end else begin
      out_ready = 1'b0;
      stall_cnt = 0;
    end
  end

  // Monitor: pops the scoreboard on each completed output handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (out_valid && !prev_ov) first_cyc = cyc;
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected out_valid", 32'(out_valid), 32'd0);
        end else if (!out_ready) begin
          chk({sb_q[0].name, " stall ovf"}, 32'(overflow_flag), 32'(sb_q[0].ovf));
          chk({sb_q[0].name, " stall unf"}, 32'(underflow_flag), 32'(sb_q[0].unf));
          chk({sb_q[0].name, " stall inv"}, 32'(invalid_flag), 32'(sb_q[0].inv));
          chk({sb_q[0].name, " stall in_ready"}, 32'(in_ready), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk({e.name, " ovf"}, 32'(overflow_flag), 32'(e.ovf));
          chk({e.name, " unf"}, 32'(underflow_flag), 32'(e.unf));
          chk({e.name, " inv"}, 32'(invalid_flag), 32'(e.inv));
          chk({e.name, " shift"}, 32'(excessive_shift_left), 32'(e.shift));
          chk({e.name, " latency"}, 32'(first_cyc - acc_cyc), 32'(e.lat));
          done_cnt++;
        end
      end
      prev_ov = out_valid;
    end
  end

  function automatic logic [4:0] dp_vec();
    return {dp_load, dp_align_en, dp_add_en, dp_norm_en, dp_out_en};
  endfunction

  // nnorm < 0: fast path; 0: zero sum; >0: number of NORM cycles.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic sum_zero, input int wait_n,
                        input int exp_v, input int stall, input int nnorm,
                        input logic e_ovf, input logic e_unf, input logic e_inv,
                        input int e_shift, input int e_lat);
    logic [4:0] ev[$];
    exp_t e;
    int start;
    bit got;
    ev.push_back(5'b10000);
    if (nnorm < 0) begin
      ev.push_back(5'b00001);
    end else begin
      ev.push_back(5'b01000);
      ev.push_back(5'b00100);
      repeat (nnorm) ev.push_back(5'b00010);
      ev.push_back(5'b00001);
    end
    e.name = name; e.ovf = e_ovf; e.unf = e_unf; e.inv = e_inv;
    e.shift = 10'(e_shift); e.lat = e_lat;
    sb_q.push_back(e);
    op_wait = wait_n; ready_delay = stall;
    dp_sum_zero = sum_zero; exp_result = 10'(exp_v);
    @(posedge clk); #1;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
    end
    chk({name, " accepted"}, 32'(got), 32'd1);
    chk($sformatf("%s pulse C0", name), 32'(dp_vec()), 32'(ev[0]));
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 32'hDEAD_BEEF; in_b = 32'h7F80_0001;
    for (int i = 1; i < ev.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s pulse C%0d", name, i), 32'(dp_vec()), 32'(ev[i]));
    end
    start = done_cnt;
    for (int i = 0; i < 300 && done_cnt == start; i++) @(negedge clk);
    chk({name, " completion"}, 32'(done_cnt > start), 32'd1);
  endtask

  task automatic reset_mid_norm();
    bit got;
    op_wait = 1000; ready_delay = 0; dp_sum_zero = 1'b0;
    @(posedge clk); #1;
    in_a = 32'h3F80_0000; in_b = 32'h4000_0000; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = dp_norm_en;
    end
    chk("rst test reached NORM", 32'(got), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst in_ready during rst", 32'(in_ready), 32'd0);
    chk("rst outputs during rst", 32'({dp_vec(), out_valid}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready after release", 32'(in_ready), 32'd1);
    chk("rst outputs after release", 32'({dp_vec(), out_valid}), 32'd0);
    chk("rst flags after release",
        32'({overflow_flag, underflow_flag, invalid_flag, excessive_shift_left}), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("rst no stray out_en", 32'({dp_out_en, out_valid}), 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset outputs", 32'({dp_vec(), out_valid}), 32'd0);
    chk("reset flags",
        32'({overflow_flag, underflow_flag, invalid_flag, excessive_shift_left}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after release", 32'(in_ready), 32'd1);

    //     name          a             b             sub  sz wait  exp  stall nnorm o  u  i  sh  lat
    run_op("1p2",        32'h3F800000, 32'h40000000, 0,   0, 0,    128, 0,    1,    0, 0, 0, 0,  5);
    run_op("ovf300",     32'h3F800000, 32'h40000000, 0,   0, 0,    300, 0,    1,    1, 0, 0, 0,  5);
    run_op("ovf255",     32'h3F800000, 32'h40000000, 0,   0, 0,    255, 0,    1,    1, 0, 0, 0,  5);
    run_op("ok254w2",    32'h3F800000, 32'h40000000, 1,   0, 2,    254, 0,    3,    0, 0, 0, 0,  7);
    run_op("unf0",       32'h3F800000, 32'h40000000, 0,   0, 0,    0,   0,    1,    0, 1, 0, 1,  5);
    run_op("unfm5",      32'h3F800000, 32'h40000000, 0,   0, 0,    -5,  0,    1,    0, 1, 0, 6,  5);
    run_op("unfm200",    32'h3F800000, 32'h40000000, 0,   0, 0,    -200, 0,   1,    0, 1, 0, 56, 5);
    run_op("nan_a",      32'h7FC00000, 32'h3F800000, 0,   0, 0,    0,   0,    -1,   0, 0, 1, 0,  2);
    run_op("inf_m_inf",  32'h7F800000, 32'hFF800000, 0,   0, 0,    0,   0,    -1,   0, 0, 1, 0,  2);
    run_op("inf_s_ninf", 32'h7F800000, 32'hFF800000, 1,   0, 0,    0,   0,    -1,   1, 0, 0, 0,  2);
    run_op("one_p_ninf", 32'h3F800000, 32'hFF800000, 0,   0, 0,    0,   0,    -1,   1, 0, 0, 0,  2);
    run_op("norm_stuck", 32'h3F800000, 32'h40000000, 0,   0, 1000, 5,   0,    56,   0, 1, 0, 0,  60);
    run_op("sum_zero",   32'h3F800000, 32'hBF800000, 0,   1, 0,    0,   0,    0,    0, 1, 0, 0,  4);
    run_op("stall3",     32'h3F800000, 32'h40000000, 0,   0, 0,    300, 3,    1,    1, 0, 0, 0,  5);
    reset_mid_norm();
    run_op("after_rst",  32'h3F800000, 32'h40000000, 0,   0, 1,    -1,  0,    2,    0, 1, 0, 2,  6);

    chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
